// File: rtl/prisc_pkg.sv
// prisc_pkg: opcode constants, sequencer state enumeration and flag bit positions.
package prisc_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam logic [5:0] OP_LOAD = 6'b011000;
    localparam logic [5:0] OP_B    = 6'b100000;
    localparam logic [5:0] OP_JAL  = 6'b101000;
    localparam logic [5:0] OP_BC   = 6'b101001;
    localparam logic [5:0] OP_BNC  = 6'b101010;
    localparam logic [5:0] OP_BR   = 6'b101011;
    localparam logic [5:0] OP_BS   = 6'b110000;
    localparam logic [5:0] OP_BZ   = 6'b110001;
    localparam logic [5:0] OP_BNZ  = 6'b110010;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [2:0] OP_MEM_CLASS = 3'b011;
    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
endpackage

// File: rtl/prisc_sequencer_if.sv
// prisc_sequencer_if: fetch, execute and data-memory handshake bundle of the sequencer.
interface prisc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        exec_start;
    logic        exec_done;
    logic        alu_zero;
    logic        alu_sign;
    logic        alu_carry;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] reg_target;
    logic        rf_we;
    logic [2:0]  flags;
    logic        halted;
    modport master (
        output imem_req, imem_addr, ir, exec_start, mem_req, rf_we, flags, halted,
        input  imem_ack, imem_rdata, exec_done, alu_zero, alu_sign, alu_carry, mem_ack, reg_target
    );
    modport slave (
        input  imem_req, imem_addr, ir, exec_start, mem_req, rf_we, flags, halted,
        output imem_ack, imem_rdata, exec_done, alu_zero, alu_sign, alu_carry, mem_ack, reg_target
    );
endinterface

// File: rtl/prisc_branch_eval.sv
// prisc_branch_eval: branch-taken decision from opcode and registered flags; unknown opcodes are not taken.
module prisc_branch_eval import prisc_pkg::*; (
    input  logic [5:0] opcode,
    input  logic [2:0] flags,
    output logic       taken
);
    assign taken = opcode == OP_B || opcode == OP_JAL || opcode == OP_BR
                || (opcode == OP_BZ  &&  flags[FLAG_Z])
                || (opcode == OP_BNZ && !flags[FLAG_Z])
                || (opcode == OP_BS  &&  flags[FLAG_S])
                || (opcode == OP_BC  &&  flags[FLAG_C])
                || (opcode == OP_BNC && !flags[FLAG_C]);
endmodule

// File: rtl/prisc_sequencer.sv
// prisc_sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT instruction sequencer.
// PRISC_LINK_EN: opcode 101000 also pulses rf_we in its branch-resolve cycle.
module prisc_sequencer import prisc_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    prisc_sequencer_if.master bus
);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, pc_inc, br_target;
    logic [2:0]  flags_q, flags_d;
    logic        run_q, run_d, taken, link_we;
    logic [5:0]  opcode;
    assign opcode    = ir_q[31:26];
    assign pc_inc    = pc_q + 32'd1;
    assign br_target = opcode == OP_BR ? bus.reg_target : pc_q + {{6{ir_q[25]}}, ir_q[25:0]};
    prisc_branch_eval u_branch_eval (.opcode(opcode), .flags(flags_q), .taken(taken));
`ifdef PRISC_LINK_EN
    assign link_we = state_q == EXEC && bus.exec_done && opcode == OP_JAL;
`else
    assign link_we = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        run_d   = 1'b1;
        case (state_q)
            FETCH: if (run_q && bus.imem_ack) begin
                ir_d    = bus.imem_rdata;
                state_d = DECODE;
            end
            DECODE: state_d = opcode == OP_HALT ? HALT : EXEC;
            EXEC: if (bus.exec_done) begin
                flags_d = opcode[5] ? flags_q : {bus.alu_carry, bus.alu_sign, bus.alu_zero};
                pc_d    = !opcode[5] ? pc_q : taken ? br_target : pc_inc;
                state_d = opcode[5:3] == OP_MEM_CLASS ? MEM : opcode[5] ? FETCH : WB;
            end
            MEM: if (bus.mem_ack) begin
                pc_d    = opcode == OP_LOAD ? pc_q : pc_inc;
                state_d = opcode == OP_LOAD ? WB : FETCH;
            end
            WB: begin
                pc_d    = pc_inc;
                state_d = FETCH;
            end
            default: ;
        endcase
    end
    // run_q holds off the first fetch request until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            run_q   <= run_d;
        end
    end
    assign bus.imem_req   = run_q && state_q == FETCH;
    assign bus.imem_addr  = pc_q;
    assign bus.ir         = ir_q;
    assign bus.exec_start = state_q == DECODE && opcode != OP_HALT;
    assign bus.mem_req    = state_q == MEM;
    assign bus.rf_we      = state_q == WB || link_we;
    assign bus.flags      = flags_q;
    assign bus.halted     = state_q == HALT;
endmodule

// File: tb/tb_prisc_sequencer.sv
// tb_prisc_sequencer: directed program table, random program vs. reference model, reset and halt sequences.
module tb_prisc_sequencer;
`ifdef PRISC_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  aluf;
        logic [31:0] tgt;
        int          mlen;
        logic [31:0] npc;
        logic [2:0]  nfl;
        int          we;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int mreq_cnt = 0;
    logic [31:0] m_pc;
    logic [2:0]  m_fl;
    int e_we, e_mq;
    prisc_sequencer_if bus();
    prisc_sequencer #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.rf_we) we_cnt <= we_cnt + 1;
        if (bus.mem_req) mreq_cnt <= mreq_cnt + 1;
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.imem_req !== 1'b1) chk("imem_req_timeout", {31'd0, bus.imem_req}, 32'd1);
    endtask
    task automatic do_instr(input logic [31:0] instr, input logic [2:0] aluf, input logic [31:0] tgt,
                            input int mlen, output logic [31:0] npc, output logic [2:0] nfl,
                            output int we, output int mq);
        int we0, mq0;
        wait_req();
        we0 = we_cnt;
        mq0 = mreq_cnt;
        bus.imem_rdata = instr;
        bus.imem_ack = 1'b1;
        bus.reg_target = tgt;
        @(negedge clk);
        bus.imem_rdata = $urandom;
        chk("ir", bus.ir, instr);
        chk("exec_start", {31'd0, bus.exec_start}, 32'd1);
        // stray strobes while in DECODE must be ignored
        bus.exec_done = 1'b1;
        {bus.alu_carry, bus.alu_sign, bus.alu_zero} = ~aluf;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.exec_done = 1'b0;
        bus.mem_ack = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.exec_done = 1'b1;
        {bus.alu_carry, bus.alu_sign, bus.alu_zero} = aluf;
        @(negedge clk);
        bus.exec_done = 1'b0;
        {bus.alu_carry, bus.alu_sign, bus.alu_zero} = 3'($urandom);
        if (instr[31:29] == 3'b011) begin
            repeat (mlen - 1) @(negedge clk);
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        wait_req();
        npc = bus.imem_addr;
        nfl = bus.flags;
        we = we_cnt - we0;
        mq = mreq_cnt - mq0;
    endtask
    task automatic model_step(input logic [31:0] instr, input logic [2:0] aluf, input logic [31:0] tgt, input int mlen);
        logic [5:0] op;
        bit tk, is_mem;
        int off;
        op = instr[31:26];
        off = $signed(instr[25:0]);
        case (op)
            6'b100000, 6'b101000, 6'b101011: tk = 1'b1;
            6'b110001: tk = m_fl[0];
            6'b110010: tk = !m_fl[0];
            6'b110000: tk = m_fl[1];
            6'b101001: tk = m_fl[2];
            6'b101010: tk = !m_fl[2];
            default:   tk = 1'b0;
        endcase
        if (op[5]) begin
            m_pc = !tk ? m_pc + 32'd1 : op == 6'b101011 ? tgt : m_pc + 32'(off);
            e_we = (LINK && op == 6'b101000) ? 1 : 0;
            e_mq = 0;
        end else begin
            is_mem = op[5:3] == 3'b011;
            m_fl = aluf;
            m_pc = m_pc + 32'd1;
            e_mq = is_mem ? mlen : 0;
            e_we = (!is_mem || op == 6'b011000) ? 1 : 0;
        end
    endtask
    initial begin
        vec_t tbl[$];
        logic [5:0] pool[16] = '{6'b000000, 6'b000101, 6'b010111, 6'b011000, 6'b011001, 6'b011111,
                                 6'b100000, 6'b101000, 6'b101001, 6'b101010, 6'b101011, 6'b110000,
                                 6'b110001, 6'b110010, 6'b111000, 6'b111110};
        logic [31:0] npc, instr, tgt, hpc;
        logic [2:0] nfl, aluf, hfl;
        int we, mq, mlen, viol;
        tbl.push_back('{32'h0000_0010, 3'b001, 32'h0, 1, 32'h0000_0001, 3'b001, 1});
        tbl.push_back('{32'h0400_0000, 3'b001, 32'h0, 1, 32'h0000_0002, 3'b001, 1});
        tbl.push_back('{32'h8000_0003, 3'b110, 32'h0, 1, 32'h0000_0005, 3'b001, 0});
        tbl.push_back('{32'hC7FF_FFFE, 3'b000, 32'h0, 1, 32'h0000_0003, 3'b001, 0});
        tbl.push_back('{32'h0000_0000, 3'b000, 32'h0, 1, 32'h0000_0004, 3'b000, 1});
        tbl.push_back('{32'h0800_0000, 3'b000, 32'h0, 1, 32'h0000_0005, 3'b000, 1});
        tbl.push_back('{32'hC7FF_FFFE, 3'b111, 32'h0, 1, 32'h0000_0006, 3'b000, 0});
        tbl.push_back('{32'hAC00_0000, 3'b111, 32'h100, 1, 32'h0000_0100, 3'b000, 0});
        tbl.push_back('{32'h6000_0000, 3'b010, 32'h0, 4, 32'h0000_0101, 3'b010, 1});
        tbl.push_back('{32'h6400_0000, 3'b100, 32'h0, 2, 32'h0000_0102, 3'b100, 0});
        tbl.push_back('{32'hA400_0010, 3'b011, 32'h0, 1, 32'h0000_0112, 3'b100, 0});
        tbl.push_back('{32'hA800_0010, 3'b011, 32'h0, 1, 32'h0000_0113, 3'b100, 0});
        tbl.push_back('{32'hC000_0010, 3'b011, 32'h0, 1, 32'h0000_0114, 3'b100, 0});
        tbl.push_back('{32'hCBFF_FFEC, 3'b011, 32'h0, 1, 32'h0000_0100, 3'b100, 0});
        tbl.push_back('{32'hE000_0005, 3'b011, 32'h0, 1, 32'h0000_0101, 3'b100, 0});
        tbl.push_back('{32'hA000_0002, 3'b011, 32'h0, 1, 32'h0000_0103, 3'b100, int'(LINK)});
        tbl.push_back('{32'hAC00_0000, 3'b000, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 3'b100, 0});
        tbl.push_back('{32'h0000_0000, 3'b101, 32'h0, 1, 32'h0000_0000, 3'b101, 1});
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.exec_done = 1'b0;
        {bus.alu_carry, bus.alu_sign, bus.alu_zero} = 3'b000;
        bus.mem_ack = 1'b0;
        bus.reg_target = '0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc", bus.imem_addr, 32'h0);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_flags", {29'd0, bus.flags}, 32'd0);
        chk("rst_strobes", {28'd0, bus.exec_start, bus.mem_req, bus.rf_we, bus.halted}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        foreach (tbl[i]) begin
            do_instr(tbl[i].instr, tbl[i].aluf, tbl[i].tgt, tbl[i].mlen, npc, nfl, we, mq);
            chk($sformatf("tbl%0d_pc", i), npc, tbl[i].npc);
            chk($sformatf("tbl%0d_flags", i), {29'd0, nfl}, {29'd0, tbl[i].nfl});
            chk($sformatf("tbl%0d_rf_we", i), we, tbl[i].we);
            chk($sformatf("tbl%0d_mem_req", i), mq, tbl[i].instr[31:29] == 3'b011 ? tbl[i].mlen : 0);
        end
        m_pc = 32'h0;
        m_fl = 3'b101;
        for (int i = 0; i < 60; i++) begin
            instr = {pool[$urandom_range(0, 15)], 26'($urandom)};
            aluf = 3'($urandom);
            tgt = $urandom;
            mlen = $urandom_range(1, 4);
            do_instr(instr, aluf, tgt, mlen, npc, nfl, we, mq);
            model_step(instr, aluf, tgt, mlen);
            chk($sformatf("rnd%0d_pc", i), npc, m_pc);
            chk($sformatf("rnd%0d_flags", i), {29'd0, nfl}, {29'd0, m_fl});
            chk($sformatf("rnd%0d_rf_we", i), we, e_we);
            chk($sformatf("rnd%0d_mem_req", i), mq, e_mq);
        end
        wait_req();
        #2 rst = 1'b1;
        #1;
        chk("midrst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("midrst_pc", bus.imem_addr, 32'h0);
        chk("midrst_flags", {29'd0, bus.flags}, 32'd0);
        chk("midrst_ir", bus.ir, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("refetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("refetch_pc", bus.imem_addr, 32'h0);
        do_instr(32'h0000_0010, 3'b001, 32'h0, 1, npc, nfl, we, mq);
        chk("alu_pc", npc, 32'h1);
        chk("alu_flags", {29'd0, nfl}, 32'd1);
        chk("alu_rf_we", we, 1);
        wait_req();
        hpc = bus.imem_addr;
        hfl = bus.flags;
        bus.imem_rdata = 32'hFC00_0000;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("halt_no_exec_start", {31'd0, bus.exec_start}, 32'd0);
        @(negedge clk);
        chk("halted", {31'd0, bus.halted}, 32'd1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack = i[0];
            bus.exec_done = !i[0];
            bus.mem_ack = i[1];
            {bus.alu_carry, bus.alu_sign, bus.alu_zero} = 3'($urandom);
            @(negedge clk);
            if (bus.imem_req || bus.mem_req || bus.exec_start || bus.rf_we || !bus.halted
                || bus.imem_addr !== hpc || bus.flags !== hfl) viol++;
        end
        bus.imem_ack = 1'b0;
        bus.exec_done = 1'b0;
        bus.mem_ack = 1'b0;
        chk("halt_quiet", viol, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("halt_exit_rst", {31'd0, bus.halted}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prisc_sequencer.md
PRISC_SEQUENCER -- requirements
Module: prisc_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port clk  in  1  single clock, all state on rising edge.
REQ-003 Port rst  in  1  reset, asynchronous, active-high.
REQ-004 Port imem_req  out  1  instruction fetch request, held until imem_ack.
REQ-005 Port imem_addr  out  32  fetch address, equal to PC.
REQ-006 Port imem_ack  in  1  fetch complete, imem_rdata valid this cycle.
REQ-007 Port imem_rdata  in  32  fetched instruction word.
REQ-008 Port ir  out  32  instruction register.
REQ-009 Port exec_start  out  1  one-cycle pulse starting datapath execution.
REQ-010 Port exec_done  in  1  datapath result and ALU flags valid.
REQ-011 Port alu_zero, alu_sign, alu_carry  in  1 each  ALU flags.
REQ-012 Port mem_req  out  1  data memory request, held until mem_ack.
REQ-013 Port mem_ack  in  1  data memory access complete.
REQ-014 Port reg_target  in  32  register operand for register-indirect branch.
REQ-015 Port rf_we  out  1  register-file write-enable pulse.
REQ-016 Port flags  out  3  registered {carry, sign, zero}.
REQ-017 Port halted  out  1  high while in HALT.

Function
REQ-018 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; sequencer SHALL never skip FETCH between instructions.
REQ-019 FETCH: imem_req=1; on imem_ack, ir<=imem_rdata, go DECODE; no timeout.
REQ-020 DECODE (1 cycle): opcode=ir[31:26]; 6'b111111 -> HALT; else pulse exec_start, go EXEC.
REQ-021 EXEC: wait exec_done; opcode[5:3]=3'b011 -> MEM; opcode[5]=0 -> WB; opcode[5]=1 (branch class) -> branch resolve, FETCH.
REQ-022 On exec_done with opcode[5]=0, flags<=ALU flags; branch and halt opcodes SHALL leave flags unchanged.
REQ-023 Branch taken: 100000, 101000, 101011 always; 110001 if zero; 110010 if !zero; 110000 if sign; 101001 if carry; 101010 if !carry; flags used are registered values, not same-cycle ALU inputs.
REQ-024 Taken target: 101011 -> reg_target; others -> PC + sign-extended ir[25:0], modulo 2^32; not taken or non-branch -> PC+1 modulo 2^32 (wrap 32'hFFFF_FFFF -> 0).
REQ-025 MEM: mem_req=1 until mem_ack; then opcode 011000 (load) -> WB, other memory opcodes -> PC+1, FETCH.
REQ-026 WB: rf_we=1 for exactly one cycle, PC<=PC+1, go FETCH.
REQ-027 Unrecognized branch-class opcode SHALL behave as not-taken branch.
REQ-028 HALT: all request/strobe outputs 0, PC and flags frozen, exit only via rst.
REQ-029 imem_ack/mem_ack/exec_done outside their wait states SHALL be ignored.
REQ-030 Latency of non-memory ALU instruction: FETCH ack + 1 DECODE + exec wait + 1 WB.

Reset
REQ-031 rst asserted at any time, including mid-handshake, SHALL immediately force state FETCH, PC=RESET_PC, ir=0, flags=0, imem_req=0, mem_req=0, exec_start=0, rf_we=0, halted=0.
REQ-032 First imem_req SHALL assert in the first clock edge after rst deasserts.

Configuration
REQ-033 Macro PRISC_LINK_EN defined: opcode 101000 additionally pulses rf_we one cycle in branch-resolve cycle (datapath writes PC+1 to link register); undefined: 101000 is plain unconditional branch, no rf_we.

Structure
REQ-034 Shared package prisc_pkg SHALL hold opcode constants, state enumeration, flag bit indices.
REQ-035 Sub-module prisc_branch_eval (combinational, opcode + flags -> taken) SHALL be instantiated once.

Verification
REQ-036 Reset, fetch 32'h0000_0010 (ALU op), exec_done with zero=1 -> flags=3'b001, rf_we one pulse, PC=1.
REQ-037 flags zero=1, fetch BZ (110001) imm=26'h3FFFFFE at PC=5 -> PC=3; with zero=0 -> PC=6.
REQ-038 BR (101011) with reg_target=32'h0000_0100 -> next imem_addr=32'h0000_0100, flags unchanged.
REQ-039 Load (011000), mem_ack delayed 4 cycles -> mem_req held 4 cycles, then single rf_we, PC+1.
REQ-040 rst pulsed while imem_req waiting -> imem_req drops same cycle, PC=RESET_PC, refetch after release.
REQ-041 Fetch 6'b111111 -> halted=1, no further imem_req for 20 cycles despite imem_ack toggling.
